// File: rtl/alu_seq_pkg.sv
// Shared types and the single-cycle compute function for alu_seq.
// Operands are zero-extended to ALU_MAX_W bits; the live width is passed in.
package alu_seq_pkg;

    localparam int ALU_MAX_W = 128;
    localparam logic [ALU_MAX_W:0] ALU_ONE = {{ALU_MAX_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_ADD = 3'd2,
        OP_XOR = 3'd3,
        OP_NOR = 3'd4,
        OP_MUL = 3'd5,
        OP_SUB = 3'd6,
        OP_SLT = 3'd7
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ALU_MAX_W-1:0] res;
        logic                 ovf;
        logic                 cy;
    } alu_res_t;

    // Bit positions of the live width are picked with masks so no variable index is needed.
    function automatic alu_res_t alu_compute(input op_t op,
                                             input logic [ALU_MAX_W-1:0] a,
                                             input logic [ALU_MAX_W-1:0] b,
                                             input int w);
        logic [ALU_MAX_W:0] mask;
        logic [ALU_MAX_W:0] msb;
        logic [ALU_MAX_W:0] bx;
        logic [ALU_MAX_W:0] sum;
        logic               sub;
        logic               a_neg;
        logic               s_neg;
        logic               ovf;
        alu_res_t           r;
        mask  = (ALU_ONE << w) - ALU_ONE;
        msb   = mask ^ (mask >> 1);
        sub   = (op == OP_SUB) || (op == OP_SLT);
        bx    = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        sum   = {1'b0, a} + bx + (sub ? ALU_ONE : {(ALU_MAX_W + 1){1'b0}});
        a_neg = |({1'b0, a} & msb);
        s_neg = |(sum & msb);
        ovf   = (a_neg == (|(bx & msb))) && (s_neg != a_neg);
        r     = '0;
        case (op)
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_XOR: r.res = a ^ b;
            OP_NOR: r.res = ~(a | b) & mask[ALU_MAX_W-1:0];
            OP_ADD, OP_SUB: begin
                r.res = sum[ALU_MAX_W-1:0] & mask[ALU_MAX_W-1:0];
                r.ovf = ovf;
                r.cy  = |(sum & ~mask);
            end
            OP_SLT: r.res = {{(ALU_MAX_W - 1){1'b0}}, s_neg ^ ovf};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// last is high during the final iteration; prod_* then show the finished product.
module alu_seq_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               active_r;

    // Accumulator after the current iteration's partial product
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign last       = active_r && (cnt_r == LAST_CNT);
    assign prod_lo    = acc_next_s[WIDTH-1:0];
    assign prod_hi_nz = |acc_next_s[2*WIDTH-1:WIDTH];

    // Operand load on start, then one shift-add step per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            active_r <= 1'b0;
        end else if (start) begin
            acc_r    <= '0;
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= '0;
            active_r <= 1'b1;
        end else if (active_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (last) begin
                cnt_r    <= '0;
                active_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier and BUSY state; otherwise code 5 is flagged illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    state_t           state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             overflow_r;
    logic             carry_r;
    logic             zero_r;
    logic             negative_r;
    logic             illegal_r;

    op_t              op_s;
    alu_res_t         alu_s;
    logic             accept_s;
    logic             mul_start_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic             mul_hi_nz_s;

    assign op_s     = op_t'(control);
    assign alu_s    = alu_compute(op_s, ALU_MAX_W'(A), ALU_MAX_W'(B), WIDTH);
    assign in_ready = (state_r == IDLE) && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    assign mul_start_s = accept_s && (op_s == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (mul_start_s),
        .a          (A),
        .b          (B),
        .last       (mul_last_s),
        .prod_lo    (mul_lo_s),
        .prod_hi_nz (mul_hi_nz_s)
    );
`else
    assign mul_start_s = 1'b0;
    assign mul_last_s  = 1'b0;
    assign mul_lo_s    = '0;
    assign mul_hi_nz_s = 1'b0;
`endif

    // Sequencing FSM and result/flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            overflow_r  <= 1'b0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            if (mul_start_s) begin
                // The previous result (if any) retires on this edge.
                state_r     <= BUSY;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b1;
                out_r       <= alu_s.res[WIDTH-1:0];
                overflow_r  <= alu_s.ovf;
                carry_r     <= alu_s.cy;
                zero_r      <= (alu_s.res == '0);
                negative_r  <= alu_s.res[WIDTH-1];
                illegal_r   <= (op_s == OP_MUL);
            end
        end else if (mul_last_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b1;
            out_r       <= mul_lo_s;
            overflow_r  <= mul_hi_nz_s;
            carry_r     <= 1'b0;
            zero_r      <= (mul_lo_s == '0);
            negative_r  <= mul_lo_s[WIDTH-1];
            illegal_r   <= 1'b0;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign overflow  = overflow_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign illegal   = illegal_r;

endmodule
